// File: rtl/mc_control_fsm.sv
// Multi-cycle RV32I main control FSM: Moore-decoded datapath controls, mem_ready stall handling, sticky stall watchdog.
// Optional MC_ILLEGAL_TRAP_EN: unknown opcodes trap (illegal_instr port) instead of retiring as a no-op.
module mc_control_fsm #(
    parameter int STALL_LIMIT = 0,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       RegWrite,
    output logic [1:0] ALUOp,
    output logic [3:0] state_o,
`ifdef MC_ILLEGAL_TRAP_EN
    output logic       illegal_instr,
`endif
    output logic       mem_timeout
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10,
        TRAP     = 4'd11
    } state_t;

    localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(STALL_LIMIT);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state;
    state_t           state_nxt;
    logic             pc_update;
    logic             branch;
    logic             ir_write;
    logic             mem_write;
    logic             reg_write;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] stall_cnt_nxt;
    logic             waiting;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = FETCH;
        pc_update = 1'b0;
        branch    = 1'b0;
        ir_write  = 1'b0;
        mem_write = 1'b0;
        reg_write = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ALUOp     = 2'b00;
        case (state)
            FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                ir_write  = mem_ready;
                pc_update = mem_ready;
                state_nxt = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    7'b0000011, 7'b0100011: state_nxt = MEMADR;
                    7'b0110011:             state_nxt = EXECR;
                    7'b0010011:             state_nxt = EXECI;
                    7'b1100011:             state_nxt = BEQ;
                    7'b1101111:             state_nxt = JAL;
`ifdef MC_ILLEGAL_TRAP_EN
                    default:                state_nxt = TRAP;
`else
                    default:                state_nxt = FETCH;
`endif
                endcase
            end
            MEMADR: begin
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b01;
                state_nxt = op[5] ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                AdrSrc    = 1'b1;
                state_nxt = mem_ready ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                reg_write = 1'b1;
            end
            MEMWRITE: begin
                // Strobe stays up until the memory port accepts the store.
                AdrSrc    = 1'b1;
                mem_write = 1'b1;
                state_nxt = mem_ready ? FETCH : MEMWRITE;
            end
            EXECR: begin
                ALUSrcA   = 2'b10;
                ALUOp     = 2'b10;
                state_nxt = ALUWB;
            end
            EXECI: begin
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b01;
                ALUOp     = 2'b10;
                state_nxt = ALUWB;
            end
            ALUWB: begin
                reg_write = 1'b1;
            end
            BEQ: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b01;
                branch  = 1'b1;
            end
            JAL: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                pc_update = 1'b1;
                state_nxt = ALUWB;
            end
            TRAP: begin
`ifdef MC_ILLEGAL_TRAP_EN
                state_nxt = TRAP;
`else
                state_nxt = FETCH;
`endif
            end
            default: state_nxt = FETCH;
        endcase
    end

    // Reset forces FETCH, whose enables would otherwise follow mem_ready.
    assign PCWrite  = (pc_update | (branch & zero)) & ~reset;
    assign IRWrite  = ir_write & ~reset;
    assign MemWrite = mem_write & ~reset;
    assign RegWrite = reg_write & ~reset;
    assign state_o  = state;

`ifdef MC_ILLEGAL_TRAP_EN
    assign illegal_instr = (state == TRAP);
`endif

    assign waiting       = ((state == FETCH) || (state == MEMREAD) || (state == MEMWRITE)) && !mem_ready;
    assign stall_cnt_nxt = !waiting ? '0 :
                           (stall_cnt == CNT_MAX) ? stall_cnt : stall_cnt + CNT_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt   <= '0;
            mem_timeout <= 1'b0;
        end else begin
            stall_cnt <= stall_cnt_nxt;
            if ((STALL_LIMIT > 0) && (stall_cnt_nxt == LIMIT)) begin
                mem_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboarded bench for mc_control_fsm: driver queues per-cycle expected state/outputs, negedge monitor compares.
// Honours MC_ILLEGAL_TRAP_EN for the illegal-opcode vectors.
module tb_mc_control_fsm;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] op = OP_R;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, mem_timeout;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
    logic [3:0] state_o;
`ifdef MC_ILLEGAL_TRAP_EN
    logic       illegal_instr;
`endif

    always #5 clk = ~clk;

    mc_control_fsm #(.STALL_LIMIT(4), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .RegWrite(RegWrite),
        .ALUOp(ALUOp), .state_o(state_o),
`ifdef MC_ILLEGAL_TRAP_EN
        .illegal_instr(illegal_instr),
`endif
        .mem_timeout(mem_timeout)
    );

    typedef struct {
        logic [3:0]  st;
        logic [13:0] o;
        int          step;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   step = 0;

    // Output vector: {PCWrite,AdrSrc,MemWrite,IRWrite,ResultSrc,ALUSrcA,ALUSrcB,RegWrite,ALUOp,mem_timeout}
    function automatic logic [13:0] spec_out(input logic [3:0] st, input logic mr, input logic z,
                                             input logic rst, input logic to);
        logic       pw, adr, mw, ir, rw;
        logic [1:0] rs, sa, sb, ao;
        pw = 0; adr = 0; mw = 0; ir = 0; rw = 0; rs = 0; sa = 0; sb = 0; ao = 0;
        case (st)
            4'd0:  begin sb = 2'b10; rs = 2'b10; ir = mr; pw = mr; end
            4'd1:  begin sa = 2'b01; sb = 2'b01; end
            4'd2:  begin sa = 2'b10; sb = 2'b01; end
            4'd3:  begin adr = 1; end
            4'd4:  begin rs = 2'b01; rw = 1; end
            4'd5:  begin adr = 1; mw = 1; end
            4'd6:  begin sa = 2'b10; ao = 2'b10; end
            4'd7:  begin sa = 2'b10; sb = 2'b01; ao = 2'b10; end
            4'd8:  begin rw = 1; end
            4'd9:  begin sa = 2'b10; ao = 2'b01; pw = z; end
            4'd10: begin sa = 2'b01; sb = 2'b10; pw = 1; end
            default: ;
        endcase
        if (rst) begin pw = 0; ir = 0; mw = 0; rw = 0; end
        return {pw, adr, mw, ir, rs, sa, sb, rw, ao, to};
    endfunction

    task automatic cyc(input logic [6:0] o, input logic mr, input logic z, input logic rst,
                       input logic [3:0] st, input logic to);
        exp_t e;
        op = o; mem_ready = mr; zero = z; reset = rst;
        e.st = st;
        e.o = spec_out(st, mr, z, rst, to);
        e.step = step;
        q.push_back(e);
        step++;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t        e;
            logic [13:0] act;
            logic        ok;
            e = q.pop_front();
            act = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                   RegWrite, ALUOp, mem_timeout};
            ok = (state_o === e.st) && (act === e.o);
`ifdef MC_ILLEGAL_TRAP_EN
            ok = ok && (illegal_instr === (e.st == 4'd11));
`endif
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL step%0d: state=%0d outs=%b, expected state=%0d outs=%b",
                         e.step, state_o, act, e.st, e.o);
            end
        end
    end

    initial begin
        @(posedge clk);
        #1;
        // reset held two cycles
        cyc(OP_R, 1, 0, 1, 0, 0);
        cyc(OP_R, 1, 0, 1, 0, 0);
        // R-type
        cyc(OP_R, 1, 0, 0, 0, 0); cyc(OP_R, 1, 0, 0, 1, 0);
        cyc(OP_R, 1, 0, 0, 6, 0); cyc(OP_R, 1, 0, 0, 8, 0);
        // lw with three wait cycles in MEMREAD
        cyc(OP_LW, 1, 0, 0, 0, 0); cyc(OP_LW, 1, 0, 0, 1, 0); cyc(OP_LW, 1, 0, 0, 2, 0);
        cyc(OP_LW, 0, 0, 0, 3, 0); cyc(OP_LW, 0, 0, 0, 3, 0); cyc(OP_LW, 0, 0, 0, 3, 0);
        cyc(OP_LW, 1, 0, 0, 3, 0); cyc(OP_LW, 1, 0, 0, 4, 0);
        // sw with one wait cycle in MEMWRITE
        cyc(OP_SW, 1, 0, 0, 0, 0); cyc(OP_SW, 1, 0, 0, 1, 0); cyc(OP_SW, 1, 0, 0, 2, 0);
        cyc(OP_SW, 0, 0, 0, 5, 0); cyc(OP_SW, 1, 0, 0, 5, 0);
        // beq taken, then not taken
        cyc(OP_BR, 1, 1, 0, 0, 0); cyc(OP_BR, 1, 1, 0, 1, 0); cyc(OP_BR, 1, 1, 0, 9, 0);
        cyc(OP_BR, 1, 0, 0, 0, 0); cyc(OP_BR, 1, 0, 0, 1, 0); cyc(OP_BR, 1, 0, 0, 9, 0);
        // I-type and jal
        cyc(OP_I, 1, 0, 0, 0, 0); cyc(OP_I, 1, 0, 0, 1, 0);
        cyc(OP_I, 1, 0, 0, 7, 0); cyc(OP_I, 1, 0, 0, 8, 0);
        cyc(OP_JAL, 1, 0, 0, 0, 0); cyc(OP_JAL, 1, 0, 0, 1, 0);
        cyc(OP_JAL, 1, 0, 0, 10, 0); cyc(OP_JAL, 1, 0, 0, 8, 0);
        // reset in the middle of an R-type: back to FETCH at once, no RegWrite
        cyc(OP_R, 1, 0, 0, 0, 0); cyc(OP_R, 1, 0, 0, 1, 0); cyc(OP_R, 1, 0, 0, 6, 0);
        cyc(OP_R, 1, 0, 1, 0, 0);
        cyc(OP_R, 1, 0, 0, 0, 0); cyc(OP_R, 1, 0, 0, 1, 0);
        cyc(OP_R, 1, 0, 0, 6, 0); cyc(OP_R, 1, 0, 0, 8, 0);
        // unrecognised opcode
        cyc(OP_BAD, 1, 0, 0, 0, 0); cyc(OP_BAD, 1, 0, 0, 1, 0);
`ifdef MC_ILLEGAL_TRAP_EN
        cyc(OP_BAD, 1, 0, 0, 11, 0); cyc(OP_BAD, 1, 0, 0, 11, 0); cyc(OP_BAD, 1, 0, 0, 11, 0);
        cyc(OP_R, 1, 0, 1, 0, 0);
`endif
        // watchdog: six wait cycles in FETCH, flag visible after the fourth
        cyc(OP_R, 0, 0, 0, 0, 0); cyc(OP_R, 0, 0, 0, 0, 0);
        cyc(OP_R, 0, 0, 0, 0, 0); cyc(OP_R, 0, 0, 0, 0, 0);
        cyc(OP_R, 0, 0, 0, 0, 1); cyc(OP_R, 0, 0, 0, 0, 1);
        cyc(OP_R, 1, 0, 0, 0, 1); cyc(OP_R, 1, 0, 0, 1, 1);
        cyc(OP_R, 1, 0, 0, 6, 1); cyc(OP_R, 1, 0, 0, 8, 1);
        cyc(OP_R, 1, 0, 0, 0, 1);
        cyc(OP_R, 1, 0, 1, 0, 0);
        cyc(OP_R, 1, 0, 0, 0, 0);

        repeat (3) @(posedge clk);
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Main control state machine for the multi-cycle RV32I core.
- Sequences one instruction at a time through fetch, decode, execute, memory and writeback.
- Drives the datapath mux selects and write enables, plus the 2-bit ALUOp consumed by the ALU decoder.
- Sits beside the ALU decoder inside the controller; inputs come from the instruction register opcode, the ALU zero flag and the shared memory port ready line.

Parameters:
STALL_LIMIT, 0, consecutive memory-wait cycles before mem_timeout sets; 0 disables the watchdog.
CNT_W, 8, width of the stall counter; STALL_LIMIT must be < 2^CNT_W.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
op  input  7  instruction opcode, instr[6:0], from the instruction register
zero  input  1  ALU zero flag
mem_ready  input  1  memory port completes the access this cycle
PCWrite  output  1  PC register enable
AdrSrc  output  1  memory address select: 0 = PC, 1 = ALU result
MemWrite  output  1  data memory write strobe
IRWrite  output  1  instruction/OldPC register enable
ResultSrc  output  2  result mux select: 00 = ALUOut, 01 = Data, 10 = ALUResult
ALUSrcA  output  2  SrcA select: 00 = PC, 01 = OldPC, 10 = rs1 data
ALUSrcB  output  2  SrcB select: 00 = rs2 data, 01 = ImmExt, 10 = constant 4
RegWrite  output  1  register file write enable
ALUOp  output  2  00 = add, 01 = sub, 10 = funct-decoded
state_o  output  4  current state encoding, for debug
mem_timeout  output  1  sticky watchdog flag

Behaviour:
- State register is 4 bits, asynchronous reset to FETCH.
  - Encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BEQ=9, JAL=10, TRAP=11.
- Outputs are Moore-decoded from the state, with these exceptions:
  - PCWrite = PCUpdate | (Branch & zero).
  - IRWrite and PCUpdate in FETCH are gated by mem_ready.
- Unlisted outputs are 0 in each state.
- While reset is high, PCWrite, IRWrite, MemWrite and RegWrite are 0 and mem_timeout is 0; all other outputs take their FETCH values.
- Per-state outputs and transitions:
  - FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, IRWrite=PCUpdate=mem_ready. Goes to DECODE if mem_ready, else stays.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target). Next state by op:
    - 0000011 (lw) or 0100011 (sw) -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1100011 -> BEQ
    - 1101111 -> JAL
    - other -> see Optional Feature
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Goes to MEMREAD if op[5]=0, else MEMWRITE.
  - MEMREAD: AdrSrc=1, ResultSrc=00. Goes to MEMWB on mem_ready, else stays.
  - MEMWB: ResultSrc=01, RegWrite=1. Goes to FETCH.
  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 held until mem_ready. Goes to FETCH on mem_ready.
  - EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Goes to ALUWB.
  - EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Goes to ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1. Goes to FETCH.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1. Goes to FETCH.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. Goes to ALUWB.
- Instruction latency with mem_ready held at 1:
  - lw = 5 cycles
  - sw = 4 cycles
  - R-type, I-type and jal = 4 cycles
  - beq = 3 cycles
  - Each 0-cycle of mem_ready in FETCH, MEMREAD or MEMWRITE adds one cycle.
- Stall watchdog:
  - Counter increments each cycle in FETCH, MEMREAD or MEMWRITE with mem_ready=0.
  - Counter clears on any mem_ready=1 or on any other state; it saturates at all-ones.
  - mem_timeout sets on the cycle after the count reaches STALL_LIMIT (STALL_LIMIT>0) and stays set until reset.
  - The FSM keeps waiting; the watchdog never alters sequencing.
- An undefined state encoding returns to FETCH on the next clock.
- Reset asserted mid-instruction: the state goes to FETCH immediately (asynchronously) and the in-flight instruction is discarded with no write strobe.

Optional Feature:
- Macro: MC_ILLEGAL_TRAP_EN.
- Defined:
  - An unrecognised opcode in DECODE goes to TRAP.
  - TRAP holds all enables at 0, state_o=11, and remains there until reset.
  - Extra output illegal_instr (1 bit) is 1 only in TRAP.
- Undefined:
  - An unrecognised opcode in DECODE returns to FETCH, i.e. it executes as a 2-cycle no-op with PC already advanced.
  - No illegal_instr port exists.

Test Plan:
- Reset high for 2 cycles, then low, with mem_ready=1 and op=0110011 -> state sequence 0,1,6,8,0; RegWrite=1 only in state 8; ALUOp=10 in state 6.
- op=0000011 with mem_ready dropped for 3 cycles in MEMREAD -> states 0,1,2,3,3,3,3,4,0; RegWrite with ResultSrc=01 exactly once.
- op=0100011 -> MemWrite=1 in state 5 only; AdrSrc=1; the next state is 0 when mem_ready=1.
- op=1100011 with zero=1, then with zero=0 -> PCWrite=1 in BEQ only when zero=1; ALUOp=01 in both cases.
- STALL_LIMIT=4, mem_ready=0 in FETCH for 6 cycles -> mem_timeout rises after the 4th wait cycle and stays 1 after mem_ready returns; clears only on reset.
- op=1111111 -> with MC_ILLEGAL_TRAP_EN: state 11 and illegal_instr=1 held. Without it: returns to state 0 and no write enable is asserted.
